// File: rtl/simple_uart_pkg.sv
// Constants shared by the UART receiver and its receive FIFO.
package simple_uart_pkg;
  localparam int DEFAULT_WORD_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Pointer width: index bits plus one wrap bit.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/simple_fifo_if.sv
// FIFO push/pop bundle; master is the user side, slave is the FIFO.
interface simple_fifo_if
  import simple_uart_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH
);
  logic [WORD_WIDTH-1:0]              din;
  logic                               we;
  logic                               full;
  logic [WORD_WIDTH-1:0]              dout;
  logic                               re;
  logic                               empty;
  logic [fifo_ptr_width(DEPTH)-1:0]   count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output din, we, re,
    input  full, dout, empty, count, overflow, underflow
  );

  modport slave (
    input  din, we, re,
    output full, dout, empty, count, overflow, underflow
  );
endinterface

// File: rtl/simple_fifo_mem.sv
// DEPTH x WORD_WIDTH storage: synchronous write, asynchronous read, no reset.
module simple_fifo_mem
  import simple_uart_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]         rd_addr,
  output logic [WORD_WIDTH-1:0] rd_dat
);
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];
endmodule

// File: rtl/simple_fifo.sv
// First-word fall-through FIFO: a write at edge N is visible on dout after N; full refuses writes, empty ignores pops.
// Sticky overflow/underflow flags exist only when SIMPLE_FIFO_ERROR_FLAGS_EN is defined, otherwise tied to 0.
module simple_fifo
  import simple_uart_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  simple_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          empty, full;
  logic          wr_acc, rd_acc;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign wr_acc = bus.we && !full;
  assign rd_acc = bus.re && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Writes are suppressed in the reset cycle so stale data cannot be exposed later.
  simple_fifo_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && rst),
    .wr_addr (wptr_q[AW-1:0]),
    .wr_dat  (bus.din),
    .rd_addr (rptr_q[AW-1:0]),
    .rd_dat  (bus.dout)
  );

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = wptr_q - rptr_q;

`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (bus.we && full);
    underflow_d = underflow_q || (bus.re && empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: doc/simple_fifo.md
SIMPLE_FIFO -- requirements
Module: simple_fifo

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
REQ-005 SHALL have port din  input  WORD_WIDTH  write data from the UART receiver.
REQ-006 SHALL have port we  input  1  write strobe, one word per asserted cycle.
REQ-007 SHALL have port full  output  1  no free entry.
REQ-008 SHALL have port dout  output  WORD_WIDTH  head-of-queue word, valid while empty=0 (first-word fall-through).
REQ-009 SHALL have port re  input  1  pop strobe.
REQ-010 SHALL have port empty  output  1  no stored entry.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overflow  output  1  sticky: write refused while full (macro-dependent).
REQ-013 SHALL have port underflow  output  1  sticky: pop requested while empty (macro-dependent).

Function
REQ-014 SHALL keep write and read pointers of $clog2(DEPTH)+1 bits; MSB is the wrap bit, pointers wrap modulo 2*DEPTH.
REQ-015 SHALL derive empty = (wptr == rptr) and full = (index bits equal, wrap bits differ), both from registered pointers.
REQ-016 SHALL derive count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
REQ-017 SHALL accept a write only when we=1 and full=0; the word is stored at wptr and wptr increments.
REQ-018 SHALL refuse a write when full=1, even if re=1 in the same cycle; the memory and wptr are left unchanged.
REQ-019 SHALL perform a pop only when re=1 and empty=0; rptr increments.
REQ-020 SHALL ignore re when empty=1, even if we=1 in the same cycle; the written word is retained.
REQ-021 SHALL, on simultaneous accepted write and pop, change both pointers so that count is unchanged.
REQ-022 SHALL present a word written at edge N on dout with empty=0 after edge N (zero added bubble); dout is combinational from memory[rptr].
REQ-023 SHALL leave dout content unspecified while empty=1.

Reset
REQ-024 SHALL, while rst=0 at posedge, clear wptr, rptr, overflow and underflow, giving empty=1, full=0, count=0.
REQ-025 SHALL NOT clear memory contents on reset.
REQ-026 SHALL, if reset is asserted mid-stream, discard all stored words and ignore we/re in that cycle.

Configuration
REQ-027 SHALL, with SIMPLE_FIFO_ERROR_FLAGS_EN defined, set overflow on any refused write and underflow on any ignored pop; both stay set until reset.
REQ-028 SHALL, without SIMPLE_FIFO_ERROR_FLAGS_EN defined, tie overflow and underflow to 0 and synthesize no flag registers; all other behaviour is identical.

Structure
REQ-029 SHALL place shared constants (default WORD_WIDTH, default FIFO depth) in package simple_uart_pkg, for use by both the receiver and this block.
REQ-030 SHALL instantiate one sub-module, simple_fifo_mem: DEPTH x WORD_WIDTH array with a synchronous write port and an asynchronous read port.
REQ-031 SHALL keep pointer and flag control in simple_fifo, with no state machine beyond the pointers and flags.

Verification
REQ-032 SHALL cover reset, then writes of 0x11, 0x22, 0x33 on consecutive cycles -> empty=0 one cycle after the first write, count=3, pops return 0x11, 0x22, 0x33 in order, then empty=1.
REQ-033 SHALL cover 16 writes with DEPTH=16 -> full=1 and count=16; a 17th write of 0xAA with re=1 is refused, overflow=1 (macro on), and the popped word is the first one written.
REQ-034 SHALL cover re=1 and we=1 (0x5C) while empty -> no pop, underflow=1 (macro on), then count=1 and dout=0x5C.
REQ-035 SHALL cover 40 write/pop pairs at count=8 -> count stays 8, pointers wrap past 2*DEPTH, and the data order is preserved.
REQ-036 SHALL cover rst=0 for one cycle at count=5 -> empty=1, count=0, overflow=0, underflow=0; a next write of 0x77 gives dout=0x77.
REQ-037 SHALL cover a build without SIMPLE_FIFO_ERROR_FLAGS_EN repeating REQ-033 and REQ-034 -> overflow and underflow stay 0.
